// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU, single-cycle logic/arith plus iterative MULU and DIVU.
// Define SEQ_ALU_DIV_EN to compile in the restoring divider (opcode 1001).
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a, r_y, r_hi;
    logic               r_ovf;
    logic [2*WIDTH-1:0] r_acc, w_acc_mul, w_acc_next;
    logic [WIDTH:0]     w_mac;
    logic [WIDTH-1:0]   w_add, w_sub, w_y;
    logic               w_ovf_add, w_ovf_sub, w_ovf;
    logic               w_accept, w_last, w_is_mul, w_is_div;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = r_cnt == CW'(WIDTH - 1);
    assign w_is_mul  = f == 4'b1000;
    assign w_add     = a + b;
    assign w_sub     = a - b;
    assign w_ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
    assign w_ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);

    // Shift-add: low half of r_acc starts as b and is consumed LSB first.
    assign w_mac     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_acc_mul = {w_mac, r_acc[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   w_rem, w_dif;
    // Restoring divide: r_acc = {remainder, dividend bits shifting into quotient}.
    assign w_is_div   = f == 4'b1001;
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_dif      = w_rem - {1'b0, r_b};
    assign w_acc_next = (r_state != S_DIV) ? w_acc_mul :
                        w_dif[WIDTH] ? {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                                       {w_dif[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
`else
    assign w_is_div   = 1'b0;
    assign w_acc_next = w_acc_mul;
`endif

    always_comb begin
        w_y   = '0;
        w_ovf = 1'b0;
        case (f)
            4'b0000: w_y = a & b;
            4'b0001: w_y = a | b;
            4'b0010: begin w_y = w_add; w_ovf = w_ovf_add; end
            4'b0110: begin w_y = w_sub; w_ovf = w_ovf_sub; end
            4'b0111: w_y = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_ovf_sub};
            4'b1010: w_y = a ^ b;
            4'b1011: w_y = ~(a | b);
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_accept) w_next = w_is_mul ? S_MUL : w_is_div ? S_DIV : S_DONE;
            S_MUL, S_DIV: if (w_last) w_next = S_DONE;
            S_DONE:       if (out_ready) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_acc <= '0;
            r_y   <= '0;
            r_hi  <= '0;
            r_ovf <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            r_b   <= '0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= a;
            r_acc <= {{WIDTH{1'b0}}, w_is_div ? a : b};
`ifdef SEQ_ALU_DIV_EN
            r_b   <= b;
`endif
            if (!w_is_mul && !w_is_div) begin
                r_y   <= w_y;
                r_hi  <= '0;
                r_ovf <= w_ovf;
            end
        end else if (r_state == S_MUL || r_state == S_DIV) begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= w_acc_next;
            if (w_last) begin
                r_y   <= w_acc_next[WIDTH-1:0];
                r_hi  <= w_acc_next[2*WIDTH-1:WIDTH];
                r_ovf <= 1'b0;
            end
        end
    end

    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign y         = r_y;
    assign hi        = r_hi;
    assign ovf       = r_ovf;
    assign zero      = r_y == '0;
endmodule
